nibble_stream_tx: RTL and testbench
===================================

NIBBLE_STREAM_TX -- requirements
Module: nibble_stream_tx

Interface
- REQ-001: clk  input  1  sole clock; all state updates on the rising edge.
- REQ-002: rst_n  input  1  reset, synchronous, active-low.
- REQ-003: A  input  8  operand byte A, sampled on the input handshake.
- REQ-004: B  input  8  operand byte B, sampled on the input handshake.
- REQ-005: in_valid  input  1  upstream holds a valid A/B pair.
- REQ-006: in_ready  output  1  block can accept a pair; high only in IDLE.
- REQ-007: out_valid  output  1  current nibble beat on the output is valid.
- REQ-008: out_ready  input  1  downstream accepts the current beat.
- REQ-009: nib_a  output  4  nibble of captured A for the current beat.
- REQ-010: nib_b  output  4  nibble of captured B for the current beat.
- REQ-011: ctrl  output  1  nibble select: 0 = low nibble beat, 1 = high nibble beat.
- REQ-012: q  output  5  nibble sum for the current beat.
- REQ-013: last  output  1  high on the final (high-nibble) beat.
- REQ-014: total  output  9  registered full result of the last completed pair.
- REQ-015: total_valid  output  1  one-cycle pulse when total updates.
- REQ-016: txn_cnt  output  8  count of completed pairs; wraps 255->0.

Function
- REQ-017: The FSM SHALL have states IDLE, LO and HI.
- REQ-018: In IDLE with in_valid=1, the block SHALL capture A and B at the edge, then move to LO; input handshake = in_valid & in_ready.
- REQ-019: In LO: out_valid=1, ctrl=0, last=0, nib_a=A[3:0], nib_b=B[3:0], q=A[3:0]+B[3:0]; on out_ready move to HI and register carry_lo=q[4].
- REQ-020: In HI: out_valid=1, ctrl=1, last=1, nib_a=A[7:4], nib_b=B[7:4], q per REQ-030/031; on out_ready move to IDLE.
- REQ-021: On the HI handshake edge: total SHALL load, total_valid SHALL be high for exactly the following cycle, and txn_cnt SHALL increment modulo 256.
- REQ-022: Latency: the first beat is valid in the cycle after the input handshake; minimum pair period is 3 cycles.
- REQ-023: While out_valid=1 and out_ready=0, nib_a, nib_b, q, ctrl and last SHALL hold stable.
- REQ-024: in_valid SHALL be ignored outside IDLE; A/B changes after capture SHALL NOT affect output.
- REQ-025: In IDLE: out_valid=0, and nib_a, nib_b, q, ctrl and last SHALL be 0.
- REQ-026: total SHALL hold its value between completed pairs.

Reset
- REQ-027: rst_n=0 at a clock edge SHALL force IDLE from any state, including mid-beat or stalled, discarding the in-flight pair without updating total or txn_cnt.
- REQ-028: After reset: in_ready=1, out_valid=0, nib_a=0, nib_b=0, ctrl=0, q=0, last=0, total=0, total_valid=0, txn_cnt=0, captured operands=0, carry_lo=0.

Configuration
- REQ-029: Macro NIBBLE_CARRY_EN SHALL select carry chaining between the two beats.
- REQ-030: With NIBBLE_CARRY_EN defined: HI q=A[7:4]+B[7:4]+carry_lo (max 31); total=A+B (9-bit).
- REQ-031: Without it: HI q=A[7:4]+B[7:4]; total={q_hi, q_lo[3:0]}, so the low-nibble carry is dropped.

Verification
- REQ-032: A=0x24, B=0x81, out_ready=1 -> LO q=0x05, ctrl=0; HI q=0x0A, ctrl=1, last=1; total=0x0A5, total_valid pulse; txn_cnt=1.
- REQ-033: A=0x0D, B=0x8D -> LO q=0x1A; HI q=0x09 and total=0x09A with NIBBLE_CARRY_EN; HI q=0x08 and total=0x08A without it.
- REQ-034: A=0xF9, B=0xC6 with NIBBLE_CARRY_EN -> LO q=0x0F; HI q=0x1B; total=0x1BF.
- REQ-035: A=0x65, B=0x12 with out_ready=0 for 4 cycles in LO -> q=0x07 held stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> HI q=0x07, total=0x077.
- REQ-036: rst_n=0 for one edge during HI of a pair -> all outputs at reset values next cycle, total unchanged from before reset (0 after reset), no total_valid pulse.
- REQ-037: Complete 256 pairs -> txn_cnt wraps 255->0 on the 256th HI handshake.

Source files
------------

// File: rtl/nibble_stream_tx_if.sv
// Stream bus for nibble_stream_tx: operand handshake in, nibble beats out.
// master = the environment (drives operands and out_ready),
// slave  = the nibble transmitter (drives beats and in_ready).
interface nibble_stream_tx_if;
    logic [7:0] A;
    logic [7:0] B;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic       ctrl;
    logic [4:0] q;
    logic       last;

    modport master (
        output A, B, in_valid, out_ready,
        input  in_ready, out_valid, nib_a, nib_b, ctrl, q, last
    );

    modport slave (
        input  A, B, in_valid, out_ready,
        output in_ready, out_valid, nib_a, nib_b, ctrl, q, last
    );
endinterface

// File: rtl/nibble_stream_tx.sv
// nibble_stream_tx: captures an A/B byte pair and emits it as two nibble
// beats (low then high), each carrying the nibble sum q. On the high-beat
// handshake the 9-bit total is registered, total_valid pulses for one
// cycle and txn_cnt increments (wrapping).
// Build option: define NIBBLE_CARRY_EN to chain the low-nibble carry into
// the high beat (total = A+B). Without it the low carry is dropped and
// total = {q_hi, q_lo[3:0]}.
module nibble_stream_tx (
    input  logic                     clk,
    input  logic                     rst_n,
    nibble_stream_tx_if.slave        bus,
    output logic [8:0]               total,
    output logic                     total_valid,
    output logic [7:0]               txn_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] a_r;
    logic [7:0] b_r;
    logic [4:0] lo_sum;
    logic [4:0] hi_sum;
    logic [4:0] hi_q;
`ifdef NIBBLE_CARRY_EN
    logic       carry_lo;
`endif

    // Nibble sums of the captured operands.
    assign lo_sum = {1'b0, a_r[3:0]} + {1'b0, b_r[3:0]};
    assign hi_sum = {1'b0, a_r[7:4]} + {1'b0, b_r[7:4]};

`ifdef NIBBLE_CARRY_EN
    // High beat absorbs the low-nibble carry (max 15+15+1 = 31).
    assign hi_q = hi_sum + {4'd0, lo_sum[4]};
`else
    assign hi_q = hi_sum;
`endif

    // Beat sequencer: state, captured operands, registered beat outputs and
    // the per-pair result/counter all update together on the clock edge.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking would make ordering inside the
    // block change the hardware.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous (sampled on the edge) and clears every
        // register, including the operand holding registers.
        if (!rst_n) begin
            state         <= IDLE;
            a_r           <= '0;
            b_r           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.nib_a     <= '0;
            bus.nib_b     <= '0;
            bus.ctrl      <= 1'b0;
            bus.q         <= '0;
            bus.last      <= 1'b0;
            total         <= '0;
            total_valid   <= 1'b0;
            txn_cnt       <= '0;
`ifdef NIBBLE_CARRY_EN
            carry_lo      <= 1'b0;
`endif
        end else begin
            total_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r           <= bus.A;
                        b_r           <= bus.B;
                        state         <= LO;
                        bus.in_ready  <= 1'b0;
                        bus.out_valid <= 1'b1;
                        bus.ctrl      <= 1'b0;
                        bus.last      <= 1'b0;
                        bus.nib_a     <= bus.A[3:0];
                        bus.nib_b     <= bus.B[3:0];
                        bus.q         <= {1'b0, bus.A[3:0]} + {1'b0, bus.B[3:0]};
                    end
                end
                LO: begin
                    if (bus.out_ready) begin
                        state     <= HI;
                        bus.ctrl  <= 1'b1;
                        bus.last  <= 1'b1;
                        bus.nib_a <= a_r[7:4];
                        bus.nib_b <= b_r[7:4];
                        bus.q     <= hi_q;
`ifdef NIBBLE_CARRY_EN
                        carry_lo  <= lo_sum[4];
`endif
                    end
                end
                HI: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.in_ready  <= 1'b1;
                        bus.out_valid <= 1'b0;
                        bus.ctrl      <= 1'b0;
                        bus.last      <= 1'b0;
                        bus.nib_a     <= '0;
                        bus.nib_b     <= '0;
                        bus.q         <= '0;
`ifdef NIBBLE_CARRY_EN
                        total         <= {hi_sum + {4'd0, carry_lo}, lo_sum[3:0]};
`else
                        total         <= {hi_sum, lo_sum[3:0]};
`endif
                        total_valid   <= 1'b1;
                        txn_cnt       <= txn_cnt + 8'd1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_stream_tx.sv
// Self-checking bench for nibble_stream_tx: table of operand pairs with
// expected beat sums and totals, a beat scoreboard queue, plus hand-written
// stall, mid-pair reset and counter-wrap sequences.
module tb_nibble_stream_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] total;
    logic       total_valid;
    logic [7:0] txn_cnt;

    always #5 clk = ~clk;

    nibble_stream_tx_if bus();

    nibble_stream_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .total       (total),
        .total_valid (total_valid),
        .txn_cnt     (txn_cnt)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         stall;
        logic [4:0] lo_q;
        logic [4:0] hi_q;
        logic [8:0] tot;
    } vec_t;

    typedef struct packed {
        logic [3:0] na;
        logic [3:0] nb;
        logic       ctrl;
        logic [4:0] q;
        logic       last;
    } beat_t;

    int         checks = 0;
    int         errors = 0;
    beat_t      sb[$];
    logic [7:0] exp_cnt;
    vec_t       vecs[7];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected values straight from the nibble arithmetic.
    function automatic vec_t model(input logic [7:0] a, input logic [7:0] b);
        vec_t       m;
        logic [4:0] lo;
        lo      = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        m.a     = a;
        m.b     = b;
        m.stall = 0;
        m.lo_q  = lo;
`ifdef NIBBLE_CARRY_EN
        m.hi_q  = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'd0, lo[4]};
        m.tot   = {1'b0, a} + {1'b0, b};
`else
        m.hi_q  = {1'b0, a[7:4]} + {1'b0, b[7:4]};
        m.tot   = {m.hi_q, lo[3:0]};
`endif
        return m;
    endfunction

    task automatic check_idle(input string name);
        check({name, "_out_valid"}, bus.out_valid, 0);
        check({name, "_in_ready"},  bus.in_ready,  1);
        check({name, "_nib_a"},     bus.nib_a,     0);
        check({name, "_nib_b"},     bus.nib_b,     0);
        check({name, "_q"},         bus.q,         0);
        check({name, "_ctrl"},      bus.ctrl,      0);
        check({name, "_last"},      bus.last,      0);
    endtask

    task automatic check_beat(input string name, input beat_t e);
        check({name, "_out_valid"}, bus.out_valid, 1);
        check({name, "_in_ready"},  bus.in_ready,  0);
        check({name, "_nib_a"},     bus.nib_a,     e.na);
        check({name, "_nib_b"},     bus.nib_b,     e.nb);
        check({name, "_ctrl"},      bus.ctrl,      e.ctrl);
        check({name, "_q"},         bus.q,         e.q);
        check({name, "_last"},      bus.last,      e.last);
    endtask

    task automatic run_pair(input vec_t v);
        beat_t e;
        check("pre_in_ready", bus.in_ready, 1);
        bus.A        = v.a;
        bus.B        = v.b;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        sb.push_back('{v.a[3:0], v.b[3:0], 1'b0, v.lo_q, 1'b0});
        sb.push_back('{v.a[7:4], v.b[7:4], 1'b1, v.hi_q, 1'b1});
        step();
        // Operands change after capture and must not reach the output.
        bus.A = ~v.a;
        bus.B = ~v.b;
        for (int s = 0; s < v.stall; s++) begin
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b0;
            check_beat("lo_stall", sb[0]);
            step();
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            bus.out_ready = 1'b1;
            check_beat(k == 0 ? "lo" : "hi", e);
            check("no_total_pulse_mid_pair", total_valid, 0);
            step();
        end
        bus.out_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        check("total_valid_pulse", total_valid, 1);
        check("total",             total,       v.tot);
        check("txn_cnt",           txn_cnt,     exp_cnt);
        check_idle("post_pair");
        step();
        check("total_valid_drop", total_valid, 0);
        check("total_hold",       total,       v.tot);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{8'h24, 8'h81, 0, 5'h05, 5'h0A, 9'h0A5};
`ifdef NIBBLE_CARRY_EN
        vecs[1] = '{8'h0D, 8'h8D, 0, 5'h1A, 5'h09, 9'h09A};
        vecs[4] = '{8'hFF, 8'hFF, 1, 5'h1E, 5'h1F, 9'h1FE};
`else
        vecs[1] = '{8'h0D, 8'h8D, 0, 5'h1A, 5'h08, 9'h08A};
        vecs[4] = '{8'hFF, 8'hFF, 1, 5'h1E, 5'h1E, 9'h1EE};
`endif
        vecs[2] = '{8'hF9, 8'hC6, 0, 5'h0F, 5'h1B, 9'h1BF};
        vecs[3] = '{8'h65, 8'h12, 4, 5'h07, 5'h07, 9'h077};
        vecs[5] = '{8'h00, 8'h00, 2, 5'h00, 5'h00, 9'h000};
        vecs[6] = '{8'h37, 8'hA8, 0, 5'h0F, 5'h0D, 9'h0DF};

        rst_n         = 1'b0;
        bus.A         = 8'h5A;
        bus.B         = 8'hA5;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        exp_cnt       = 8'd0;
        step();
        step();
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        check_idle("reset");
        check("reset_total",       total,       0);
        check("reset_total_valid", total_valid, 0);
        check("reset_txn_cnt",     txn_cnt,     0);

        // Table-driven pairs.
        for (int i = 0; i < 7; i++) run_pair(vecs[i]);

        // Reset while the high beat is on the bus (with out_ready high).
        v = model(8'h9C, 8'h47);
        bus.A         = v.a;
        bus.B         = v.b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("pre_reset_in_hi", bus.ctrl, 1);
        rst_n = 1'b0;
        step();
        rst_n         = 1'b1;
        bus.out_ready = 1'b0;
        check_idle("mid_reset");
        check("mid_reset_total",       total,       0);
        check("mid_reset_total_valid", total_valid, 0);
        check("mid_reset_txn_cnt",     txn_cnt,     0);
        sb.delete();
        exp_cnt = 8'd0;
        step();
        check("mid_reset_no_pulse", total_valid, 0);
        check_idle("mid_reset_settled");

        // 256 pairs: the counter wraps to 0 on the last high-beat handshake.
        for (int i = 0; i < 256; i++) begin
            run_pair(model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))));
            if (i == 254) check("cnt_255", txn_cnt, 8'd255);
        end
        check("cnt_wrap", txn_cnt, 8'd0);
        check("sb_empty", 16'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
